// File: rtl/rect_drop_fsm.sv
// Per-frame vertical motion sequencer for the falling rectangle.
// Q-format position/velocity, gravity with a cap, and damped floor bounce with rest detection.
module rect_drop_fsm #(
    parameter int unsigned       Y_START      = 0,
    parameter int unsigned       Y_FLOOR      = 552,
    parameter logic signed [8:0] GRAVITY      = 9'sd2,
    parameter logic signed [8:0] V_MAX        = 9'sd240,
    parameter int unsigned       BOUNCE_SHIFT = 1,
    parameter logic signed [8:0] V_REST       = 9'sd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vs,
    input  logic              m_left,
    output logic [11:0]       ypos,
    output logic signed [8:0] velocity,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFall = 2'd1,
        StRest = 2'd2
    } state_e;

    localparam logic [15:0] YStartFx = 16'(Y_START << 4);
    localparam logic [15:0] YFloorFx = 16'(Y_FLOOR << 4);

    state_e            state_q;
    logic [15:0]       ypos_fx_q;
    logic signed [8:0] velocity_q;
    logic              vs_q;
    logic              m_left_q;
    logic              pend_q;

    logic              frame_ev;
    logic              rise;
    logic              arm;
    logic signed [9:0] v_sum;
    logic signed [8:0] v_nxt;
    logic signed [9:0] v_ext;
    logic signed [16:0] p_nxt;
    logic [9:0]        v_mag;
    logic [9:0]        m;
    logic              at_rest;
    logic signed [8:0] bounce_v;
    logic              below_start;
    logic              at_floor;

    assign frame_ev = vs_q & ~vs;
    assign rise     = m_left & ~m_left_q;
    // An edge landing in the event cycle itself still arms this frame.
    assign arm      = pend_q | rise;

    always_comb begin
        v_sum       = $signed({velocity_q[8], velocity_q}) + $signed({GRAVITY[8], GRAVITY});
        v_nxt       = (v_sum > $signed({V_MAX[8], V_MAX})) ? V_MAX : v_sum[8:0];
        p_nxt       = $signed({1'b0, ypos_fx_q}) + $signed({{8{v_nxt[8]}}, v_nxt});
        v_ext       = $signed({v_nxt[8], v_nxt});
        v_mag       = v_ext[9] ? 10'(-v_ext) : 10'(v_ext);
        m           = v_mag >> BOUNCE_SHIFT;
        at_rest     = m < {1'b0, V_REST};
        bounce_v    = -$signed(m[8:0]);
        below_start = p_nxt < $signed({1'b0, YStartFx});
        at_floor    = p_nxt >= $signed({1'b0, YFloorFx});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ypos_fx_q  <= YStartFx;
            velocity_q <= '0;
            vs_q       <= 1'b0;
            m_left_q   <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            vs_q     <= vs;
            m_left_q <= m_left;
            if (frame_ev) begin
                pend_q <= 1'b0;
            end else if (rise) begin
                pend_q <= 1'b1;
            end

            if (frame_ev) begin
                case (state_q)
                    StIdle: begin
                        if (arm) begin
                            state_q <= StFall;
                        end
                    end
                    StFall: begin
                        if (below_start) begin
                            ypos_fx_q  <= YStartFx;
                            velocity_q <= v_nxt;
                        end else if (at_floor) begin
                            ypos_fx_q <= YFloorFx;
                            if (at_rest) begin
                                velocity_q <= '0;
                                state_q    <= StRest;
                            end else begin
                                velocity_q <= bounce_v;
                            end
                        end else begin
                            ypos_fx_q  <= p_nxt[15:0];
                            velocity_q <= v_nxt;
                        end
                    end
                    StRest: begin
                        if (arm) begin
                            state_q   <= StIdle;
                            ypos_fx_q <= YStartFx;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ypos     = ypos_fx_q[15:4];
    assign velocity = velocity_q;
    assign state    = state_q;

endmodule

// File: tb/tb_rect_drop_fsm.sv
// Bench for rect_drop_fsm: three parameterisations run in lockstep, checked against
// hand-derived table rows and an integer scoreboard model.
module tb_rect_drop_fsm;

    logic              clk = 1'b0;
    logic              rst;
    logic              vs;
    logic              m_left;
    logic [11:0]       ypos_w [3];
    logic signed [8:0] vel_w  [3];
    logic [1:0]        st_w   [3];

    always #5 clk = ~clk;

    rect_drop_fsm u_def (
        .clk(clk), .rst(rst), .vs(vs), .m_left(m_left),
        .ypos(ypos_w[0]), .velocity(vel_w[0]), .state(st_w[0])
    );

    rect_drop_fsm #(.Y_FLOOR(4000)) u_cap (
        .clk(clk), .rst(rst), .vs(vs), .m_left(m_left),
        .ypos(ypos_w[1]), .velocity(vel_w[1]), .state(st_w[1])
    );

    rect_drop_fsm #(.Y_FLOOR(20), .GRAVITY(9'sd32)) u_bnc (
        .clk(clk), .rst(rst), .vs(vs), .m_left(m_left),
        .ypos(ypos_w[2]), .velocity(vel_w[2]), .state(st_w[2])
    );

    typedef struct {
        int inst;
        int st;
        int y;
        int v;
    } exp_t;

    typedef struct {
        int press;  // 0 none, 1 pulse before the frame, 2 edge in the event cycle
        int d_st, d_y, d_v;
        int b_st, b_y, b_v;
    } row_t;

    int    checks   = 0;
    int    failures = 0;
    int    frame_no = 0;
    exp_t  sb_q[$];
    row_t  tbl[13];
    string inst_name[3] = '{"def", "cap", "bnc"};

    int m_st[3];
    int m_fx[3];
    int m_v[3];
    int p_g[3]     = '{2, 2, 32};
    int p_floor[3] = '{552 * 16, 4000 * 16, 20 * 16};
    bit m_pend;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0;
            m_fx[i] = 0;
            m_v[i]  = 0;
        end
        m_pend = 1'b0;
    endtask

    task automatic model_step();
        int vn, p, mag;
        for (int i = 0; i < 3; i++) begin
            if (m_st[i] == 0) begin
                if (m_pend) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                vn = m_v[i] + p_g[i];
                if (vn > 240) vn = 240;
                p = m_fx[i] + vn;
                if (p < 0) begin
                    m_fx[i] = 0;
                    m_v[i]  = vn;
                end else if (p >= p_floor[i]) begin
                    m_fx[i] = p_floor[i];
                    mag = (vn < 0 ? -vn : vn) / 2;
                    if (mag < 16) begin
                        m_v[i]  = 0;
                        m_st[i] = 2;
                    end else begin
                        m_v[i] = -mag;
                    end
                end else begin
                    m_fx[i] = p;
                    m_v[i]  = vn;
                end
            end else if (m_pend) begin
                m_st[i] = 0;
                m_fx[i] = 0;
            end
        end
        m_pend = 1'b0;
    endtask

    task automatic press_pulse();
        @(negedge clk) m_left = 1'b1;
        @(negedge clk) m_left = 1'b0;
        m_pend = 1'b1;
    endtask

    // One frame: vs high for a cycle, then low; the update lands on the next edge.
    task automatic frame(input bit sync_press);
        exp_t e;
        @(negedge clk) vs = 1'b1;
        @(negedge clk) vs = 1'b0;
        if (sync_press) begin
            m_left = 1'b1;
            m_pend = 1'b1;
        end
        model_step();
        for (int i = 0; i < 3; i++) begin
            e.inst = i;
            e.st   = m_st[i];
            e.y    = m_fx[i] / 16;
            e.v    = m_v[i];
            sb_q.push_back(e);
        end
        @(negedge clk) m_left = 1'b0;
        frame_no++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("f%0d.%s.state", frame_no, inst_name[e.inst]),
                  int'(st_w[e.inst]), e.st);
            check($sformatf("f%0d.%s.ypos", frame_no, inst_name[e.inst]),
                  int'(ypos_w[e.inst]), e.y);
            check($sformatf("f%0d.%s.vel", frame_no, inst_name[e.inst]),
                  int'(vel_w[e.inst]), e.v);
        end
    endtask

    initial begin
        int cap_mf;

        tbl[0]  = '{1, 1, 0, 0,  1, 0, 0};
        tbl[1]  = '{0, 1, 0, 2,  1, 2, 32};
        tbl[2]  = '{0, 1, 0, 4,  1, 6, 64};
        tbl[3]  = '{0, 1, 0, 6,  1, 12, 96};
        tbl[4]  = '{0, 1, 1, 8,  1, 20, -64};
        tbl[5]  = '{1, 1, 1, 10, 1, 18, -32};
        tbl[6]  = '{0, 1, 2, 12, 1, 18, 0};
        tbl[7]  = '{0, 1, 3, 14, 1, 20, -16};
        tbl[8]  = '{0, 1, 4, 16, 2, 20, 0};
        tbl[9]  = '{0, 1, 5, 18, 2, 20, 0};
        tbl[10] = '{1, 1, 6, 20, 0, 0, 0};
        tbl[11] = '{0, 1, 8, 22, 0, 0, 0};
        tbl[12] = '{2, 1, 9, 24, 1, 0, 0};

        rst    = 1'b0;
        vs     = 1'b0;
        m_left = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset.%s.state", inst_name[i]), int'(st_w[i]), 0);
            check($sformatf("reset.%s.ypos", inst_name[i]), int'(ypos_w[i]), 0);
            check($sformatf("reset.%s.vel", inst_name[i]), int'(vel_w[i]), 0);
        end
        @(negedge clk) rst = 1'b1;

        repeat (3) frame(1'b0);

        for (int r = 0; r < 13; r++) begin
            if (tbl[r].press == 1) press_pulse();
            frame(tbl[r].press == 2);
            check($sformatf("row%0d.def.state", r), int'(st_w[0]), tbl[r].d_st);
            check($sformatf("row%0d.def.ypos", r), int'(ypos_w[0]), tbl[r].d_y);
            check($sformatf("row%0d.def.vel", r), int'(vel_w[0]), tbl[r].d_v);
            check($sformatf("row%0d.bnc.state", r), int'(st_w[2]), tbl[r].b_st);
            check($sformatf("row%0d.bnc.ypos", r), int'(ypos_w[2]), tbl[r].b_y);
            check($sformatf("row%0d.bnc.vel", r), int'(vel_w[2]), tbl[r].b_v);
        end

        // Cap instance has had 12 motion frames so far.
        cap_mf = 12;
        for (int k = 0; k < 200; k++) begin
            frame(1'b0);
            cap_mf++;
            check($sformatf("cap.le_vmax.mf%0d", cap_mf), int'(vel_w[1] <= 9'sd240), 1);
            if (cap_mf == 119) check("cap.mf119", int'(vel_w[1]), 238);
            if (cap_mf == 120) check("cap.mf120", int'(vel_w[1]), 240);
        end
        check("cap.final_vel", int'(vel_w[1]), 240);
        check("cap.final_state", int'(st_w[1]), 1);

        // Asynchronous reset in the middle of a clock period while falling.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset.cap.state", int'(st_w[1]), 0);
        check("midreset.cap.ypos", int'(ypos_w[1]), 0);
        check("midreset.cap.vel", int'(vel_w[1]), 0);
        check("midreset.def.ypos", int'(ypos_w[0]), 0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) frame(1'b0);
        check("postreset.cap.ypos", int'(ypos_w[1]), 0);
        check("postreset.cap.state", int'(st_w[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rect_drop_fsm.md
# rect_drop_fsm

Per-frame motion sequencer for the falling rectangle in the VGA pipeline. It updates the rectangle's vertical position once per frame, on the falling edge of `vs`, using Q-format velocity with gravity, a velocity cap, floor bounce with damping, and rest detection. It arms on the left mouse button. It drives `ypos` into the rectangle draw stage and exposes `velocity` and `state` for debug and bench inspection.

## Interface

Parameters:
- `Y_START`, 0: top (spawn) row, integer pixels.
- `Y_FLOOR`, 552: floor row (600 visible − 48 rect height), integer pixels.
- `GRAVITY`, 9'sd2: per-frame velocity increment, Q5.4 (0.125 px/frame²).
- `V_MAX`, 9'sd240: downward velocity cap, Q5.4 (15.0 px/frame).
- `BOUNCE_SHIFT`, 1: damping on bounce. Velocity magnitude is right-shifted by this amount.
- `V_REST`, 9'sd16: if post-bounce magnitude is below this, enter rest (Q5.4, 1.0 px/frame).

Ports:
- `clk`, in, 1: pixel-domain clock (40 MHz).
- `rst`, in, 1: asynchronous, active-low reset.
- `vs`, in, 1: vertical sync from the timing generator, synchronous to `clk`.
- `m_left`, in, 1: left mouse button level, synchronous to `clk`.
- `ypos`, out, 12: rectangle top row, integer part of the internal position.
- `velocity`, out, 9: signed Q5.4 velocity, positive means downward.
- `state`, out, 2: 0 = IDLE, 1 = FALL, 2 = REST.

## Operation

- **Internal position:** `ypos_fx`, unsigned 16 bit, Q12.4. `ypos` = `ypos_fx[15:4]`.
- **Frame event:** asserted for exactly one cycle when `vs_q`=1 and `vs`=0, where `vs_q` is `vs` registered.
- **Arm flag:** `pend` is set on a rising edge of `m_left` (`m_left`=1, `m_left_q`=0). It is cleared on every frame event, whether or not it was used. A rising edge in the same cycle as a frame event counts for that event.
- **IDLE:**
  - Holds `ypos_fx` = `Y_START`<<4 and `velocity` = 0.
  - On a frame event with `pend`: go to FALL. No motion is applied in that frame.
- **FALL, on each frame event:**
  - `v_nxt` = min(`velocity` + `GRAVITY`, `V_MAX`), with signed compare.
  - `p_nxt` = `ypos_fx` + sign-extended `v_nxt`.
  - If `p_nxt` < `Y_START`<<4 (a signed result goes negative or below start): clamp to `Y_START`<<4 and keep `v_nxt`.
  - If `p_nxt` ≥ `Y_FLOOR`<<4: set `ypos_fx` = `Y_FLOOR`<<4 and set `m` = |`v_nxt`| >> `BOUNCE_SHIFT`.
    - If `m` < `V_REST`: `velocity` = 0 and go to REST.
    - Otherwise: `velocity` = −`m`, stay in FALL.
  - Otherwise: `ypos_fx` = `p_nxt`, `velocity` = `v_nxt`.
  - `pend` is ignored in FALL.
- **REST:**
  - Holds position at the floor with `velocity` 0.
  - On a frame event with `pend`: go to IDLE and set `ypos_fx` = `Y_START`<<4 in the same update.
- **Outside frame events:** all state and outputs hold.
- **Overflow:** intermediates are 10-bit signed for velocity and 17-bit for position, so no overflow is possible within parameter ranges.

## Timing

- **Reset values:**
  - `state` = IDLE, `ypos` = `Y_START`, `velocity` = 0.
  - `pend`, `vs_q`, `m_left_q` = 0.
  - `vs_q` resets to 0, so the first `vs` low after reset does not produce an event until `vs` has been seen high.
- **Latency:** outputs change on the first `clk` edge after the frame-event cycle, i.e. one cycle after `vs` is sampled low. There is exactly one update per frame.
- **Reset mid-operation:** outputs return to their reset values asynchronously, regardless of state.
- **`vs` glitch:** a low pulse of one cycle still yields one event. A second falling edge within the same frame yields another event; no filtering is done.

## Test plan

- **Reset:** assert `rst`=0 mid-FALL → `ypos`=0, `velocity`=0, `state`=0 immediately. After release, `ypos` stays 0 with no `m_left` over 3 frames.
- **Arm:** pulse `m_left` for 1 cycle, then run frames (defaults).
  - Frame 1: `state`→1, `ypos`=0.
  - Frame 2: `velocity`=2.
  - Frame 9: `velocity`=16, `ypos_fx`=72, so `ypos`=4.
- **Velocity cap:** keep falling with `Y_FLOOR`=4000 → `velocity` saturates at 240 after 120 FALL frames and never exceeds it.
- **Bounce:** with `Y_FLOOR`=20, GRAVITY=32:
  - The first floor crossing gives `ypos`=20 and a negative velocity equal to −(`v_nxt`>>1).
  - `ypos` then decreases on the next frame.
- **Rest and rearm:** continue the bounce test until `m` < 16 → `state`=2, `velocity`=0, `ypos`=20. Then pulse `m_left` → next frame `state`=0, `ypos`=0.
- **Simultaneous events:** a `m_left` rising edge in the frame-event cycle while IDLE → FALL on that event. A `m_left` pulse during FALL must not cause a rearm after REST is reached.
